// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: 4-way regfile write arbiter; req/req_reg/req_data in, registered gnt/ctrl_writeEnable/ctrl_writeReg/data_writeReg/busy out
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clock,
  input  logic                ctrl_reset_n,
  input  logic [3:0]          req,
  input  logic [4*ADDR_W-1:0] req_reg,
  input  logic [4*DATA_W-1:0] req_data,
  output logic [3:0]          gnt,
  output logic                ctrl_writeEnable,
  output logic [ADDR_W-1:0]   ctrl_writeReg,
  output logic [DATA_W-1:0]   data_writeReg,
  output logic                busy
);
  logic [1:0] rr_last, c1, c2, win;
  logic [3:0] elig;
  logic found;
  logic [ADDR_W-1:0] win_reg;
  logic [DATA_W-1:0] win_data;
  always_comb begin
    elig = req & ~gnt;
    c1 = (rr_last == 2'd3) ? 2'd1 : rr_last + 2'd1;
    c2 = (c1 == 2'd3) ? 2'd1 : c1 + 2'd1;
    found = |elig;
    win = elig[0] ? 2'd0 : elig[c1] ? c1 : elig[c2] ? c2 : rr_last;
    win_reg = req_reg[win*ADDR_W +: ADDR_W];
    win_data = req_data[win*DATA_W +: DATA_W];
  end
  always_ff @(posedge clock or negedge ctrl_reset_n)
    if (!ctrl_reset_n) begin
      gnt <= '0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg <= '0;
      data_writeReg <= '0;
      busy <= 1'b0;
      rr_last <= 2'd3;
    end else begin
      gnt <= found ? 4'b0001 << win : 4'b0000;
      ctrl_writeEnable <= found && (win_reg != '0);
      busy <= $countones(elig) > 1;
      if (found) begin
        ctrl_writeReg <= win_reg;
        data_writeReg <= win_data;
        if (win != 2'd0) rr_last <= win;
      end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed and random checks of regfile_write_arbiter against a reference model
module tb_regfile_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  logic clock = 1'b0;
  logic ctrl_reset_n;
  logic [3:0] req;
  logic [4*AW-1:0] req_reg;
  logic [4*DW-1:0] req_data;
  logic [3:0] gnt;
  logic ctrl_writeEnable;
  logic [AW-1:0] ctrl_writeReg;
  logic [DW-1:0] data_writeReg;
  logic busy;
  int checks = 0;
  int errors = 0;
  logic [3:0] m_gnt;
  int m_rr;
  logic m_we;
  logic [AW-1:0] m_reg;
  logic [DW-1:0] m_data;
  logic m_busy;
  logic written_f [4];
  int issued = 0;
  int written = 0;
  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock(clock),
    .ctrl_reset_n(ctrl_reset_n),
    .req(req),
    .req_reg(req_reg),
    .req_data(req_data),
    .gnt(gnt),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg),
    .busy(busy)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_gnt = '0;
    m_rr = 3;
    m_we = 1'b0;
    m_reg = '0;
    m_data = '0;
    m_busy = 1'b0;
  endtask
  task automatic set_req(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d);
    req[i] = 1'b1;
    req_reg[i*AW +: AW] = r;
    req_data[i*DW +: DW] = d;
  endtask
  task automatic tick();
    logic [3:0] elig;
    int w, n;
    elig = req & ~m_gnt;
    n = 0;
    w = -1;
    for (int i = 0; i < 4; i++) n += int'(elig[i]);
    if (elig[0]) w = 0;
    else for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (m_rr + k - 1) % 3 + 1;
      if (w < 0 && elig[idx]) w = idx;
    end
    @(posedge clock);
    #1;
    m_busy = n > 1;
    if (w < 0) begin
      m_gnt = '0;
      m_we = 1'b0;
    end else begin
      m_gnt = 4'(1 << w);
      m_reg = req_reg[w*AW +: AW];
      m_data = req_data[w*DW +: DW];
      m_we = m_reg != '0;
      if (w > 0) m_rr = w;
    end
    chk("gnt", gnt, m_gnt);
    chk("we", ctrl_writeEnable, m_we);
    chk("wreg", ctrl_writeReg, m_reg);
    chk("wdata", data_writeReg, m_data);
    chk("busy", busy, m_busy);
    chk("onehot0", $onehot0(gnt), 1);
    chk("we_onehot", !ctrl_writeEnable || $onehot(gnt), 1);
  endtask
  initial begin
    ctrl_reset_n = 1'b1;
    req = '0;
    req_reg = '0;
    req_data = '0;
    model_reset();
    #1 ctrl_reset_n = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_we", ctrl_writeEnable, 0);
    chk("rst_reg", ctrl_writeReg, 0);
    chk("rst_data", data_writeReg, 0);
    chk("rst_busy", busy, 0);
    @(posedge clock);
    #1 ctrl_reset_n = 1'b1;
    set_req(1, 5, 32'h1111);
    set_req(2, 6, 32'h2222);
    set_req(3, 7, 32'h3333);
    tick(); chk("rr_g1", gnt, 4'b0010); chk("rr_r1", ctrl_writeReg, 5); chk("rr_b1", busy, 1);
    tick(); chk("rr_g2", gnt, 4'b0100); chk("rr_r2", ctrl_writeReg, 6); chk("rr_b2", busy, 1);
    tick(); chk("rr_g3", gnt, 4'b1000); chk("rr_r3", ctrl_writeReg, 7); chk("rr_b3", busy, 1);
    tick(); chk("rr_g4", gnt, 4'b0010); chk("rr_r4", ctrl_writeReg, 5); chk("rr_b4", busy, 1);
    req = '0;
    tick(); tick();
    set_req(0, 3, 32'hA0);
    set_req(1, 4, 32'hA1);
    tick(); chk("p0_g1", gnt, 4'b0001);
    tick(); chk("p0_g2", gnt, 4'b0010);
    tick(); chk("p0_g3", gnt, 4'b0001);
    tick(); chk("p0_g4", gnt, 4'b0010);
    req = '0;
    tick(); tick();
    set_req(2, 9, 32'hDEADBEEF);
    tick(); chk("solo_g1", gnt, 4'b0100); chk("solo_we1", ctrl_writeEnable, 1); chk("solo_r1", ctrl_writeReg, 9); chk("solo_d1", data_writeReg, 32'hDEADBEEF); chk("solo_b1", busy, 0);
    tick(); chk("solo_g2", gnt, 4'b0000); chk("solo_we2", ctrl_writeEnable, 0); chk("solo_r2", ctrl_writeReg, 9);
    tick(); chk("solo_g3", gnt, 4'b0100); chk("solo_we3", ctrl_writeEnable, 1);
    req = '0;
    tick(); tick();
    set_req(3, 0, 32'h1234);
    tick(); chk("r0_g", gnt, 4'b1000); chk("r0_we", ctrl_writeEnable, 0); chk("r0_reg", ctrl_writeReg, 0); chk("r0_data", data_writeReg, 32'h1234);
    req = '0;
    tick(); tick();
    set_req(1, 4, 32'hCAFE);
    tick(); chk("mid_g", gnt, 4'b0010);
    #2 ctrl_reset_n = 1'b0;
    #1;
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_we", ctrl_writeEnable, 0);
    chk("mid_rst_data", data_writeReg, 0);
    model_reset();
    @(posedge clock);
    #1 ctrl_reset_n = 1'b1;
    tick(); chk("rel_g", gnt, 4'b0010); chk("rel_reg", ctrl_writeReg, 4); chk("rel_data", data_writeReg, 32'hCAFE);
    req = '0;
    tick(); tick();
    for (int i = 0; i < 4; i++) written_f[i] = 1'b0;
    for (int cyc = 0; cyc < 460; cyc++) begin
      tick();
      for (int i = 0; i < 4; i++) if (gnt[i]) begin
        chk("sb_once", written_f[i], 0);
        chk("sb_reg", ctrl_writeReg, req_reg[i*AW +: AW]);
        chk("sb_data", data_writeReg, req_data[i*DW +: DW]);
        written_f[i] = 1'b1;
        written++;
      end
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) req[i] = 1'b0;
        if (cyc < 400 && !req[i] && $urandom_range(1) == 1) begin
          set_req(i, AW'($urandom_range(31)), $urandom);
          written_f[i] = 1'b0;
          issued++;
        end
      end
    end
    chk("sb_drained", req, 0);
    chk("sb_count", written, issued);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
